// File: rtl/mar_mbr_mem_if.sv
// rtl/mar_mbr_mem_if.sv - MAR/MBR registers and req/ack RAM transaction engine
module mar_mbr_mem_if #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       control_signal,
  input  logic [ADDR_W-1:0] from_PC,
  input  logic [DATA_W-1:0] from_ACC,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] to_PC,
  output logic [7:0]        to_IR,
  output logic [DATA_W-1:0] to_ACC,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mbr;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic              err_q;

  // Decoded control word bits used by this block
  logic c_mar_pc, c_mar_mbr, c_rd, c_wr, c_mbr_acc;
  logic start, start_conflict, in_idle, in_access, timeout_hit;

  assign c_mar_pc       = control_signal[2];
  assign c_mar_mbr      = control_signal[3];
  assign c_rd           = control_signal[4];
  assign c_wr           = control_signal[5];
  assign c_mbr_acc      = control_signal[8];
  assign start          = c_rd ^ c_wr;
  assign start_conflict = c_rd & c_wr;
  assign in_idle        = (state == S_IDLE);
  assign in_access      = (state == S_ACCESS);
  assign timeout_hit    = (cnt == CNT_W'(TIMEOUT - 1));

  // Remaining control word bits belong to other datapath blocks
  logic unused_ctrl;
  assign unused_ctrl = ^{control_signal[31:9], control_signal[7:6], control_signal[1:0]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: an ack in the final allowed cycle still completes normally
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (mem_ack)          state_nxt = S_DONE;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Wait counter and latched direction of the current transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      we_q <= 1'b0;
    end else if (in_idle && start) begin
      cnt  <= '0;
      we_q <= c_wr;
    end else if (in_access && !mem_ack) begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // Sticky error: conflicting start bits or access timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    err_q <= 1'b0;
    else if (in_idle && start_conflict)            err_q <= 1'b1;
    else if (in_access && !mem_ack && timeout_hit) err_q <= 1'b1;
  end

  // MAR: loads only in IDLE, and not on a start cycle so the access sees the old address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       mar <= '0;
    else if (in_idle && !start) begin
      if (c_mar_pc)                   mar <= from_PC;
      else if (c_mar_mbr)             mar <= mbr[ADDR_W-1:0];
    end
  end

  // MBR: ACC load in IDLE, RAM data captured on the acked edge of a read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             mbr <= '0;
    else if (in_idle && c_mbr_acc)          mbr <= from_ACC;
    else if (in_access && mem_ack && !we_q) mbr <= mem_rdata;
  end

  assign mem_req   = in_access;
  assign mem_we    = in_access & we_q;
  assign mem_addr  = mar;
  assign mem_wdata = mbr;
  assign to_PC     = mbr[ADDR_W-1:0];
  assign to_IR     = mbr[15:8];
  assign to_ACC    = mbr;
  assign busy      = (state == S_ACCESS) || (state == S_DONE);
  assign done      = (state == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_mar_mbr_mem_if.sv
// tb/tb_mar_mbr_mem_if.sv - randomized self-checking bench for mar_mbr_mem_if
module tb_mar_mbr_mem_if;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   ctrl = '0;
  logic [AW-1:0] from_pc = '0;
  logic [DW-1:0] from_acc = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          mem_req, mem_we, busy, done, err;
  logic [AW-1:0] mem_addr, to_pc;
  logic [DW-1:0] mem_wdata, to_acc;
  logic [7:0]    to_ir;

  mar_mbr_mem_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .control_signal(ctrl), .from_PC(from_pc),
    .from_ACC(from_acc), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .to_PC(to_pc), .to_IR(to_ir), .to_ACC(to_acc), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [AW-1:0] m_mar;
  logic [DW-1:0] m_mbr;
  logic          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ctl_cycle(input logic [31:0] c);
    ctrl = c;
    tick();
    ctrl = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".addr"},  mem_addr,  m_mar);
    chk({tag, ".wdata"}, mem_wdata, m_mbr);
    chk({tag, ".to_pc"}, to_pc,     m_mbr[AW-1:0]);
    chk({tag, ".to_ir"}, to_ir,     m_mbr[15:8]);
    chk({tag, ".to_acc"}, to_acc,   m_mbr);
    chk({tag, ".err"},   err,       m_err);
    chk({tag, ".req"},   mem_req,   1'b0);
    chk({tag, ".busy"},  busy,      1'b0);
    chk({tag, ".done"},  done,      1'b0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #2;
    m_mar = '0; m_mbr = '0; m_err = 1'b0;
    chk("rst.we", mem_we, 1'b0);
    chk_idle("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Runs one transaction; the RAM acks on ACCESS cycle index wt (no ack at all if wt >= TO).
  // MAR/MBR load bits are thrown at the block during ACCESS and must be ignored.
  task automatic access(input bit wr, input int wt, input logic [DW-1:0] rd, input string tag);
    int reqc, donec;
    reqc = 0; donec = 0;
    ctl_cycle(wr ? 32'h20 : 32'h10);
    for (int c = 0; c < TO + 6; c++) begin
      if (mem_req) begin
        chk({tag, ".we"},   mem_we,   wr);
        chk({tag, ".hold"}, mem_addr, m_mar);
        if (reqc == wt) begin mem_ack = 1'b1; mem_rdata = rd; end
        reqc++;
        from_pc = AW'($urandom); from_acc = DW'($urandom);
        ctrl = $urandom_range(0, 1) ? 32'h10C : 32'h0;
      end else if (!done && $urandom_range(0, 3) == 0) begin
        mem_ack = 1'b1; mem_rdata = DW'($urandom);
      end
      if (done) donec++;
      tick();
      mem_ack = 1'b0; ctrl = '0;
    end
    if (wt < TO) begin
      chk({tag, ".reqc"}, reqc, wt + 1);
      chk({tag, ".done"}, donec, 1);
      if (!wr) m_mbr = rd;
    end else begin
      chk({tag, ".reqc"}, reqc, TO);
      chk({tag, ".done"}, donec, 0);
      m_err = 1'b1;
    end
    chk_idle(tag);
  endtask

  initial begin
    logic [DW-1:0] v;
    m_mar = '0; m_mbr = '0; m_err = 1'b0;
    #2;
    chk("rst0.we", mem_we, 1'b0);
    chk_idle("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    from_pc = 8'h2A; ctl_cycle(32'h4); m_mar = 8'h2A;
    chk_idle("ld_pc");

    access(1'b0, 2, 16'h1234, "rd2");
    chk("rd2.ir", to_ir, 8'h12);
    chk("rd2.pc", to_pc, 8'h34);

    from_pc = 8'h10; ctl_cycle(32'h4); m_mar = 8'h10;
    from_acc = 16'hBEEF; ctl_cycle(32'h100); m_mbr = 16'hBEEF;
    access(1'b1, 0, 16'h5555, "wr0");
    chk("wr0.wdata", mem_wdata, 16'hBEEF);

    access(1'b0, TO + 3, 16'h9999, "tmo");
    access(1'b0, 1, 16'hA5C3, "rd_after_tmo");

    do_reset();
    ctl_cycle(32'h30); m_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("conf.req", mem_req, 1'b0);
      tick();
    end
    chk_idle("conf");

    from_acc = 16'h0077; ctl_cycle(32'h100); m_mbr = 16'h0077;
    from_pc = 8'h05; ctl_cycle(32'hC); m_mar = 8'h05;
    chk_idle("c2c3");
    ctl_cycle(32'h8); m_mar = 8'h77;
    chk_idle("c3");

    ctl_cycle(32'h10);
    tick(); tick();
    chk("mid.req_before", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid.req", mem_req, 1'b0);
    chk("mid.mbr", to_acc, 16'h0);
    m_mar = '0; m_mbr = '0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    access(1'b0, 1, 16'hC0DE, "rd_after_rst");

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 7))
        0: begin from_pc = AW'($urandom); m_mar = from_pc; ctl_cycle(32'h4); end
        1: begin m_mar = m_mbr[AW-1:0]; ctl_cycle(32'h8); end
        2: begin from_pc = AW'($urandom); m_mar = from_pc; ctl_cycle(32'hC); end
        3: begin v = DW'($urandom); from_acc = v; m_mbr = v; ctl_cycle(32'h100); end
        4: access(1'b0, $urandom_range(0, TO + 2), DW'($urandom), "rnd_rd");
        5: access(1'b1, $urandom_range(0, TO + 2), DW'($urandom), "rnd_wr");
        6: begin m_err = 1'b1; ctl_cycle(32'h30); tick(); end
        default: do_reset();
      endcase
      chk_idle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
